// File: rtl/gray_pkg.sv
// Shared definitions for the Gray counter step sequencer: FSM state encoding,
// the div_sel-to-period rule and the prescaler width rule.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Step period in clk cycles for a given base distance and divider select.
  function automatic int unsigned step_period(input int unsigned distance,
                                              input logic [1:0] div_sel);
    return distance << div_sel;
  endfunction

  // Prescaler width with headroom for the largest divider select.
  function automatic int prescale_width(input int n, input int distance);
    return n + 2 + $clog2(distance);
  endfunction

endpackage

// File: rtl/gray_counter_ctrl_if.sv
// Control/status bundle between the sequencer and whoever drives it; the
// sequencer takes the slave side.
interface gray_counter_ctrl_if;
  import gray_pkg::*;

  logic       start;
  logic       stop;
  logic       clear;
  logic       oneshot;
  logic [1:0] div_sel;
  logic       cnt_en;
  logic       cnt_clr;
  logic       wrap;
  logic       busy;
  state_t     state;

  modport master (
    output start, stop, clear, oneshot, div_sel,
    input  cnt_en, cnt_clr, wrap, busy, state
  );

  modport slave (
    input  start, stop, clear, oneshot, div_sel,
    output cnt_en, cnt_clr, wrap, busy, state
  );

endinterface

// File: rtl/step_prescaler.sv
// Cycle prescaler: counts 0..period-1 while run is high and flags the terminal
// count combinationally so the caller can register it alongside its own state.
module step_prescaler #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] period,
  input  logic         run,
  input  logic         zero,
  output logic         tick
);

  logic [W-1:0] count_reg;

  assign tick = run && (count_reg == (period - W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (zero) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= tick ? '0 : count_reg + W'(1);
    end
  end

endmodule

// File: rtl/gray_counter_ctrl.sv
// Start/stop/clear sequencer that paces the enable and clear of an external
// N-bit Gray counter, with optional one-sweep mode and a wrap indication.
module gray_counter_ctrl
  import gray_pkg::*;
#(
  parameter int N        = 4,
  parameter int DISTANCE = 10
) (
  input logic               clk,
  input logic               rst,
  gray_counter_ctrl_if.slave bus
);

  localparam int            PW       = prescale_width(N, DISTANCE);
  localparam logic [N-1:0]  STEP_MAX = '1;

  state_t        state_reg, state_next;
  logic [PW-1:0] period_reg;
  logic [N-1:0]  step_reg;
  logic          cnt_en_reg, cnt_clr_reg, wrap_reg, busy_reg;
  logic          run, zero, load, clr_next, tick, start_ok;

  // start only counts when no higher-priority request shares its cycle
  assign start_ok = bus.start && !bus.stop && !bus.clear;

  step_prescaler #(.W(PW)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .period (period_reg),
    .run    (run),
    .zero   (zero),
    .tick   (tick)
  );

  always_comb begin
    state_next = state_reg;
    run        = 1'b0;
    zero       = 1'b0;
    load       = 1'b0;
    clr_next   = 1'b0;
    if (bus.clear) begin
      state_next = IDLE;
      zero       = 1'b1;
      clr_next   = 1'b1;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start_ok) begin
            state_next = RUN;
            zero       = 1'b1;
            load       = 1'b1;
            clr_next   = 1'b1;
          end
        end
        RUN: begin
          // The prescaler is frozen in the stop cycle and the final wrap cycle
          if (bus.stop) begin
            state_next = PAUSE;
          end else if (wrap_reg && bus.oneshot) begin
            state_next = DONE;
          end else begin
            run = 1'b1;
          end
        end
        PAUSE: begin
          if (start_ok) begin
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      period_reg  <= '0;
      step_reg    <= '0;
      cnt_en_reg  <= 1'b0;
      cnt_clr_reg <= 1'b0;
      wrap_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_en_reg  <= tick;
      wrap_reg    <= tick && (step_reg == STEP_MAX);
      cnt_clr_reg <= clr_next;
      busy_reg    <= (state_next == RUN);
      if (load) begin
        period_reg <= PW'(step_period(DISTANCE, bus.div_sel));
      end
      if (zero) begin
        step_reg <= '0;
      end else if (tick) begin
        step_reg <= step_reg + N'(1);
      end
    end
  end

  assign bus.cnt_en  = cnt_en_reg;
  assign bus.cnt_clr = cnt_clr_reg;
  assign bus.wrap    = wrap_reg;
  assign bus.busy    = busy_reg;
  assign bus.state   = state_reg;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Scoreboard bench for gray_counter_ctrl: stimulus queues expected pulses with
// their cycle numbers, a monitor matches every cnt_en/cnt_clr pulse against them.
module tb_gray_counter_ctrl;
  import gray_pkg::*;

  typedef struct {
    int cycle;
    bit is_clr;
    bit wrap;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  gray_counter_ctrl_if bus ();

  gray_counter_ctrl #(.N(4), .DISTANCE(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic push_en(input int cycle, input bit w);
    exp_t e;
    e.cycle  = cycle;
    e.is_clr = 1'b0;
    e.wrap   = w;
    exp_q.push_back(e);
  endtask

  task automatic push_clr(input int cycle);
    exp_t e;
    e.cycle  = cycle;
    e.is_clr = 1'b1;
    e.wrap   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge; the request is sampled at the next rising edge, s.
  task automatic issue(input bit st, input bit sp, input bit cl,
                       input bit exp_clr, output int s);
    bus.start = st;
    bus.stop  = sp;
    bus.clear = cl;
    s = cyc + 1;
    if (exp_clr) push_clr(s);
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
    end else begin
      $display("check %s cycle=%0d value=%0d ok", name, cyc, got);
    end
  endtask

  task automatic score(input bit is_clr, input bit w);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s cycle=%0d got=pulse want=none",
               is_clr ? "cnt_clr" : "cnt_en", cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cycle != cyc || e.is_clr != is_clr || e.wrap != w) begin
        errors++;
        $display("FAIL pulse_match got=(cycle=%0d clr=%0d wrap=%0d) want=(cycle=%0d clr=%0d wrap=%0d)",
                 cyc, is_clr, w, e.cycle, e.is_clr, e.wrap);
      end else begin
        $display("pulse %s cycle=%0d wrap=%0d ok", is_clr ? "cnt_clr" : "cnt_en", cyc, w);
      end
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.cnt_clr === 1'b1) score(1'b1, 1'b0);
      if (bus.cnt_en === 1'b1) begin
        score(1'b0, bus.wrap);
      end else if (bus.wrap === 1'b1) begin
        errors++;
        $display("FAIL wrap_without_cnt_en cycle=%0d got=1 want=0", cyc);
      end
    end
  end

  // Stimulus
  initial begin
    int s;
    int r;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.clear   = 1'b0;
    bus.oneshot = 1'b0;
    bus.div_sel = 2'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_state", int'(bus.state), 0);
    check_val("reset_busy", int'(bus.busy), 0);
    check_val("reset_cnt_en", int'(bus.cnt_en), 0);
    check_val("reset_cnt_clr", int'(bus.cnt_clr), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_after_release", int'(bus.state), 0);

    // One-shot sweep, period 10: pulses at +10..+160, wrap on the 16th
    bus.oneshot = 1'b1;
    bus.div_sel = 2'd0;
    issue(1'b1, 1'b0, 1'b0, 1'b1, s);
    for (int k = 1; k <= 16; k++) push_en(s + 10 * k, k == 16);
    wait_until(s + 5);
    check_val("run_state", int'(bus.state), 1);
    check_val("run_busy", int'(bus.busy), 1);
    wait_until(s + 162);
    check_val("oneshot_done_state", int'(bus.state), 3);
    check_val("oneshot_done_busy", int'(bus.busy), 0);

    // Restart from DONE with period 20; div_sel change mid-run is ignored
    bus.oneshot = 1'b0;
    bus.div_sel = 2'd1;
    issue(1'b1, 1'b0, 1'b0, 1'b1, s);
    push_en(s + 20, 1'b0);
    push_en(s + 40, 1'b0);
    push_en(s + 60, 1'b0);
    wait_until(s + 45);
    bus.div_sel = 2'd3;
    wait_until(s + 65);
    // start+stop+clear together: clear wins
    issue(1'b1, 1'b1, 1'b1, 1'b1, r);
    check_val("clear_state", int'(bus.state), 0);
    check_val("clear_busy", int'(bus.busy), 0);
    wait_until(r + 100);

    // Free-run, period 40: wraps on steps 16 and 32, continues past them
    bus.div_sel = 2'd2;
    bus.oneshot = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 1'b1, s);
    for (int k = 1; k <= 40; k++) push_en(s + 40 * k, (k == 16) || (k == 32));
    wait_until(s + 1610);
    check_val("freerun_busy", int'(bus.busy), 1);
    issue(1'b0, 1'b0, 1'b1, 1'b1, r);
    check_val("freerun_cleared", int'(bus.state), 0);

    // Pause 5 cycles after the 3rd step, resume 100 cycles later
    bus.div_sel = 2'd0;
    bus.oneshot = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 1'b1, s);
    for (int k = 1; k <= 3; k++) push_en(s + 10 * k, 1'b0);
    wait_until(s + 35);
    issue(1'b0, 1'b1, 1'b0, 1'b0, r);
    check_val("pause_state", int'(bus.state), 2);
    check_val("pause_busy", int'(bus.busy), 0);
    bus.div_sel = 2'd3;
    wait_until(s + 135);
    issue(1'b1, 1'b0, 1'b0, 1'b0, r);
    for (int k = 4; k <= 16; k++) push_en(r + 5 + 10 * (k - 4), k == 16);
    wait_until(r + 127);
    check_val("resume_done_state", int'(bus.state), 3);

    // Reset mid-run after step 7
    bus.div_sel = 2'd0;
    bus.oneshot = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 1'b1, s);
    for (int k = 1; k <= 7; k++) push_en(s + 10 * k, 1'b0);
    wait_until(s + 72);
    check_val("pre_reset_busy", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check_val("async_reset_state", int'(bus.state), 0);
    check_val("async_reset_busy", int'(bus.busy), 0);
    check_val("async_reset_cnt_en", int'(bus.cnt_en), 0);
    check_val("async_reset_wrap", int'(bus.wrap), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    s = cyc;
    wait_until(s + 200);
    check_val("post_reset_state", int'(bus.state), 0);
    check_val("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
